// File: rtl/viterbi_frame_ctrl.sv
// Frame sequencer for the encoder/channel/Viterbi link: buffers one payload frame, streams it
// into the encoder with a zero flush tail, and counts decoded-bit errors against the buffer.
module viterbi_frame_ctrl #(
  parameter int unsigned FRAME_LEN = 64,
  parameter int unsigned DEC_LAT   = 24,
  localparam int unsigned CW       = $clog2(FRAME_LEN + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start_i,
  input  logic          abort_i,
  input  logic          bit_i,
  input  logic          bit_valid_i,
  output logic          bit_ready_o,
  output logic          enc_en_o,
  output logic          enc_d_o,
  input  logic          dec_bit_i,
  output logic          busy_o,
  output logic          done_o,
  output logic [CW-1:0] err_ct_o
);

  localparam int unsigned WW  = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam int unsigned RUN = FRAME_LEN + DEC_LAT;
  localparam int unsigned TW  = $clog2(RUN + 1);

  typedef enum logic [1:0] {IDLE, LOAD, SEND, DONE} state_t;

  state_t               state_q, state_d;
  logic [FRAME_LEN-1:0] frame_q;
  logic [WW-1:0]        wi_q;
  logic [TW-1:0]        t_q;
  logic [TW-1:0]        t_nxt;
  logic [WW-1:0]        rd_idx;
  logic [WW-1:0]        cmp_idx;
  logic                 load_hs;
  logic                 last_hs;
  logic                 cmp_en;
  logic                 enc_d_d;

  // Next-state, handshake and encoder-data lookahead
  always_comb begin
    load_hs = (state_q == LOAD) && bit_valid_i;
    last_hs = load_hs && (wi_q == WW'(FRAME_LEN - 1));
    t_nxt   = t_q + TW'(1);
    rd_idx  = WW'(t_nxt);
    cmp_idx = WW'(t_q - TW'(DEC_LAT));
    cmp_en  = (state_q == SEND) && (t_q >= TW'(DEC_LAT)) && !abort_i;
    state_d = state_q;
    enc_d_d = 1'b0;

    case (state_q)
      IDLE:    if (start_i) state_d = LOAD;
      LOAD:    if (last_hs) state_d = SEND;
      SEND:    if (t_q == TW'(RUN - 1)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort_i) state_d = IDLE;

    // Registered encoder bit for the upcoming SEND cycle; zeros once the payload is exhausted
    if (state_d == SEND) begin
      if (state_q == LOAD)              enc_d_d = (FRAME_LEN == 1) ? bit_i : frame_q[0];
      else if (t_nxt < TW'(FRAME_LEN))  enc_d_d = frame_q[rd_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Payload buffer carries no reset; it is fully rewritten before being read
  always_ff @(posedge clk) begin
    if (load_hs) frame_q[wi_q] <= bit_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wi_q        <= '0;
      t_q         <= '0;
      err_ct_o    <= '0;
      bit_ready_o <= 1'b0;
      enc_en_o    <= 1'b0;
      enc_d_o     <= 1'b0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
    end else begin
      bit_ready_o <= (state_d == LOAD);
      enc_en_o    <= (state_d == SEND);
      busy_o      <= (state_d == LOAD) || (state_d == SEND);
      done_o      <= (state_d == DONE);
      enc_d_o     <= enc_d_d;

      if ((state_q == IDLE) && (state_d == LOAD)) begin
        wi_q     <= '0;
        t_q      <= '0;
        err_ct_o <= '0;
      end
      if (load_hs)            wi_q <= wi_q + WW'(1);
      if (state_q == SEND)    t_q  <= t_nxt;
      if (cmp_en)             err_ct_o <= err_ct_o + CW'(dec_bit_i ^ frame_q[cmp_idx]);
    end
  end

endmodule

// File: tb/tb_viterbi_frame_ctrl.sv
// Randomized bench for viterbi_frame_ctrl: a delay-line channel with bit-flip injection feeds
// the decoder input, and a per-frame timeline derived from the frame rules sets expectations.
module tb_viterbi_frame_ctrl;

  localparam int F    = 64;
  localparam int D    = 24;
  localparam int CW   = $clog2(F + 1);
  localparam int VMAX = 4 * F;

  logic          clk = 1'b0;
  logic          rst, start_i, abort_i, bit_i, bit_valid_i, dec_bit_i;
  logic          bit_ready_o, enc_en_o, enc_d_o, busy_o, done_o;
  logic [CW-1:0] err_ct_o;

  int            n_checks = 0;
  int            n_errs   = 0;
  int            cyc      = 0;
  int            en_idx   = 0;
  logic [F-1:0]  inv_cur  = '0;
  logic [D:0]    dl       = '0;

  viterbi_frame_ctrl #(.FRAME_LEN(F), .DEC_LAT(D)) dut (
    .clk         (clk),
    .rst         (rst),
    .start_i     (start_i),
    .abort_i     (abort_i),
    .bit_i       (bit_i),
    .bit_valid_i (bit_valid_i),
    .bit_ready_o (bit_ready_o),
    .enc_en_o    (enc_en_o),
    .enc_d_o     (enc_d_o),
    .dec_bit_i   (dec_bit_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .err_ct_o    (err_ct_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s cyc=%0d got=%0d exp=%0d", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [F-1:0] rnd64();
    return {$urandom(), $urandom()};
  endfunction

  // Errors counted by compare cycle t: decoded bits k = 0 .. t-D-1
  function automatic int partial(input logic [F-1:0] inv, input int t);
    int n = 0;
    for (int k = 0; k < F; k++) if (k <= t - D - 1) n += inv[k] ? 1 : 0;
    return n;
  endfunction

  // Move to the sample point of the next cycle and advance the channel delay line
  task automatic step();
    @(negedge clk);
    for (int i = D; i > 0; i--) dl[i] = dl[i-1];
    if (enc_en_o) begin
      dl[0] = enc_d_o ^ ((en_idx < F) ? inv_cur[en_idx] : 1'b0);
      en_idx++;
    end else begin
      dl[0] = 1'($urandom);
    end
    dec_bit_i = dl[D];
  endtask

  task automatic check_outs(input logic ready, input logic en, input logic dchk, input logic d,
                            input logic busy, input logic done, input int err);
    chk("bit_ready", 32'(bit_ready_o), 32'(ready));
    chk("enc_en",    32'(enc_en_o),    32'(en));
    if (dchk) chk("enc_d", 32'(enc_d_o), 32'(d));
    chk("busy",      32'(busy_o),      32'(busy));
    chk("done",      32'(done_o),      32'(done));
    chk("err_ct",    32'(err_ct_o),    32'(err));
  endtask

  // vmode: 0 valid always, 1 pattern 1,0,0, 2 random; abort_t/rst_t: SEND index or -1
  task automatic run_frame(input logic [F-1:0] pay, input logic [F-1:0] inv, input int vmode,
                           input bit spam, input int abort_t, input int rst_t);
    logic [VMAX-1:0] vpat;
    int ones, L, done_rel, cut, last_rel, acc, t, held;
    logic vbit, e_ready, e_en, e_d;
    ones = 0;
    L    = 0;
    acc  = 0;
    for (int i = 0; i < VMAX; i++) begin
      case (vmode)
        0:       vpat[i] = 1'b1;
        1:       vpat[i] = (i % 3 == 0);
        default: vpat[i] = 1'($urandom_range(0, 1));
      endcase
      if (i >= 3 * F) vpat[i] = 1'b1;
    end
    for (int i = 0; i < VMAX && ones < F; i++) begin
      if (vpat[i]) ones++;
      L = i + 1;
    end
    done_rel = L + F + D + 1;
    cut      = (abort_t >= 0) ? L + 1 + abort_t : (rst_t >= 0) ? L + 1 + rst_t : -1;
    last_rel = (cut >= 0) ? cut + 3 : done_rel + 3;
    held     = (abort_t >= 0) ? partial(inv, abort_t) : 0;

    step();
    inv_cur     = inv;
    en_idx      = 0;
    start_i     = 1'b1;
    abort_i     = 1'b0;
    bit_valid_i = 1'b0;

    for (int rel = 1; rel <= last_rel; rel++) begin
      step();
      if (cut >= 0 && rel > cut) begin
        check_outs(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, held);
      end else begin
        t       = rel - L - 1;
        e_ready = (rel <= L);
        e_en    = (rel > L) && (rel <= L + F + D);
        e_d     = (t >= 0 && t < F) ? pay[t] : 1'b0;
        check_outs(e_ready, e_en, e_en, e_d, e_ready || e_en, rel == done_rel,
                   (rel <= L) ? 0 : (rel >= done_rel) ? partial(inv, F + D) : partial(inv, t));
      end

      start_i     = spam && (rel == 2 || rel == L + 5 || rel == done_rel);
      abort_i     = (abort_t >= 0) && (rel == cut);
      rst         = (rst_t >= 0) && (rel == cut);
      vbit        = (rel - 1 < VMAX) ? vpat[rel-1] : 1'b0;
      bit_valid_i = vbit;
      bit_i       = (vbit && acc < F) ? pay[acc] : 1'($urandom);
      if (vbit) acc++;
    end
    start_i     = 1'b0;
    abort_i     = 1'b0;
    rst         = 1'b0;
    bit_valid_i = 1'b0;
  endtask

  initial begin
    logic [F-1:0] inv;
    rst         = 1'b1;
    start_i     = 1'b0;
    abort_i     = 1'b0;
    bit_i       = 1'b0;
    bit_valid_i = 1'b0;
    dec_bit_i   = 1'b0;
    repeat (3) step();
    check_outs(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    rst = 1'b0;
    step();
    check_outs(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0);

    // abort takes priority over start in IDLE
    start_i = 1'b1;
    abort_i = 1'b1;
    step();
    start_i = 1'b0;
    abort_i = 1'b0;
    step();
    chk("abort_vs_start_ready", 32'(bit_ready_o), 32'd0);
    chk("abort_vs_start_busy",  32'(busy_o),      32'd0);

    run_frame({8{8'hA5}}, '0, 0, 1'b0, -1, -1);
    inv = '0; inv[3] = 1'b1; inv[40] = 1'b1;
    run_frame(rnd64(), inv, 0, 1'b0, -1, -1);
    inv = '0; inv[0] = 1'b1; inv[F-1] = 1'b1;
    run_frame(rnd64(), inv, 0, 1'b0, -1, -1);
    run_frame(rnd64(), '1, 0, 1'b0, -1, -1);
    run_frame(rnd64(), rnd64() & rnd64(), 1, 1'b0, -1, -1);
    run_frame(rnd64(), '0, 2, 1'b0, 30, -1);
    run_frame(rnd64(), '0, 0, 1'b0, -1, -1);
    run_frame(rnd64(), rnd64() & rnd64(), 0, 1'b1, -1, -1);
    run_frame(rnd64(), rnd64(), 2, 1'b0, -1, 10);
    run_frame(rnd64(), rnd64(), 2, 1'b0, -1, -1);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule

// File: doc/viterbi_frame_ctrl.md
# viterbi_frame_ctrl

Frame sequencer for the convolutional encoder / channel / Viterbi decoder link. It buffers one payload frame and streams it into the encoder as an unbroken run of enable cycles. It then flushes the trellis with zeros long enough for every payload bit to emerge from the decoder. Decoded bits are compared against the buffered payload and a per-frame bit-error count is reported. The block sits upstream of the encoder's enable/data inputs and taps the decoder output.

## Interface
- FRAME_LEN, 64, payload bits per frame (≥1)
- DEC_LAT, 24, fixed cycles from an enc_en_o/enc_d_o cycle to the matching decoded bit on dec_bit_i (encoder + channel register + decoder traceback); DEC_LAT ≥ 3 required (covers K−1=2 tail bits)
- CW, $clog2(FRAME_LEN+1), error-counter width (derived, not overridden)

- clk  in  1  single clock, all logic on posedge
- rst  in  1  synchronous, active-high reset
- start_i  in  1  begin a frame; sampled only in IDLE
- abort_i  in  1  return to IDLE from any state
- bit_i  in  1  payload bit
- bit_valid_i  in  1  payload bit valid
- bit_ready_o  out  1  payload bit accepted when bit_valid_i & bit_ready_o
- enc_en_o  out  1  drives encoder enable_i
- enc_d_o  out  1  drives encoder d_in
- dec_bit_i  in  1  decoder d_out
- busy_o  out  1  high in LOAD and SEND
- done_o  out  1  one-cycle pulse, frame compare complete
- err_ct_o  out  CW  bit errors in current/last frame

## Operation
- States: IDLE, LOAD, SEND, DONE.
- IDLE: outputs low.
  - start_i=1 → LOAD; clear err_ct_o, write index wi, cycle counter t.
- LOAD: bit_ready_o=1; enc_en_o=0.
  - Each handshake writes bit_i to buf[wi], wi++.
  - Gaps in bit_valid_i stall with no effect on the encoder.
  - The handshake with wi=FRAME_LEN−1 → SEND next cycle.
- SEND: enc_en_o=1 every cycle; t counts 0 … FRAME_LEN+DEC_LAT−1.
  - enc_d_o = buf[t] for t<FRAME_LEN, else 0 (tail + flush zeros).
  - For t≥DEC_LAT, with k=t−DEC_LAT: err_ct_o += dec_bit_i ^ buf[k].
  - err_ct_o updates live.
  - At t=FRAME_LEN+DEC_LAT−1 → DONE.
- DONE: lasts one cycle.
  - done_o=1; enc_en_o=0; → IDLE.
  - err_ct_o holds until the next accepted start_i.
  - start_i in DONE is ignored.
- start_i outside IDLE is ignored; no queuing.
- abort_i (any state) → IDLE next cycle.
  - bit_ready_o and enc_en_o low from that cycle.
  - No done_o; err_ct_o holds its partial value.
  - abort_i wins over start_i when both are asserted in IDLE.
- err_ct_o cannot overflow: max value FRAME_LEN fits in CW.

## Timing
- Reset values: bit_ready_o=0, enc_en_o=0, enc_d_o=0, busy_o=0, done_o=0, err_ct_o=0, state=IDLE, buffer contents don't-care.
- All outputs are registered and decoded from the current state and counters; no combinational input→output paths.
- Reset mid-frame behaves as abort, but also clears err_ct_o.
- For start_i accepted at cycle c with bit_valid_i held high:
  - bit_ready_o high on cycles c+1 … c+FRAME_LEN.
  - enc_en_o high on cycles c+FRAME_LEN+1 … c+2·FRAME_LEN+DEC_LAT.
  - done_o at c+2·FRAME_LEN+DEC_LAT+1 (defaults: start at 0 → done at 153).
- The SEND run is never interrupted, so the decoder sees a contiguous trellis.
- Each LOAD stall cycle delays all later events by one cycle.
- Compare timing: dec_bit_i is sampled in SEND cycle t; the sample is reflected in err_ct_o at t+1. The final value is valid in the done_o cycle.

## Test plan
- Clean link (bench model: dec_bit_i = enc_d_o delayed DEC_LAT), payload 0xA5 repeated, start at cycle 0 → done_o at 153, err_ct_o=0, enc_en_o high exactly 88 cycles.
- Error model inverts decoded bits k=3 and k=40 → err_ct_o=2 at done_o; k=0 and k=63 only → 2 (edge indices).
- Model inverts every decoded bit → err_ct_o=64 (full-scale, no wrap).
- bit_valid_i toggled 1,0,0,1… in LOAD → enc_en_o stays 0 until all 64 bits are accepted, then 88 contiguous enable cycles.
- abort_i at SEND t=30 → enc_en_o 0 the next cycle, no done_o, busy_o 0; a new start_i then completes normally with err_ct_o=0.
- start_i pulsed during LOAD, SEND and DONE → ignored, frame timing unchanged; rst asserted at SEND t=10 → all outputs return to reset values the next cycle.
